// File: rtl/eprom_ctrl.sv
// EPROM/flash-style storage array with read, program (AND-only), sector erase and chip erase commands.
// Optional write protect input is compiled in with `define EPROM_WP_EN.
module eprom_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int SECT_W       = 2,
    parameter int PROG_CYCLES  = 4,
    parameter int ERASE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef EPROM_WP_EN
    input  logic              wp,
`endif
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W:0] SECT_MASK = (ADDR_W + 1)'((2 ** SECT_W) - 1);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_PROG  = 2'b01;
    localparam logic [1:0] CMD_SECT  = 2'b10;
    localparam logic [1:0] CMD_CHIP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROG,
        S_ERASE_WAIT,
        S_ERASE_SWEEP
    } state_t;

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and requests seen while busy are dropped.
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] a_l, a_l_n;
    logic [DATA_W-1:0] d_l, d_l_n;
    logic [ADDR_W:0]   sw_addr, sw_addr_n;
    logic [ADDR_W:0]   sw_end, sw_end_n;
    logic [DATA_W-1:0] dout_n;
    logic              dout_valid_n;
    logic              done_n;
    logic              err_n;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] prog_old;
    logic              accept;
    logic              wp_on;

    // Power-up content is erased (all ones); contents are never cleared by rst.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

`ifdef EPROM_WP_EN
    assign wp_on = wp;
`else
    assign wp_on = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign prog_old  = mem[a_l];

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        a_l_n        = a_l;
        d_l_n        = d_l;
        sw_addr_n    = sw_addr;
        sw_end_n     = sw_end;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        done_n       = 1'b0;
        err_n        = 1'b0;
        mem_we       = 1'b0;
        mem_wa       = '0;
        mem_wd       = '0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd == CMD_READ) begin
                        dout_n       = mem[addr];
                        dout_valid_n = 1'b1;
                    end else if (wp_on) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else if (cmd == CMD_PROG) begin
                        state_n = S_PROG;
                        cnt_n   = CNT_W'(PROG_CYCLES - 1);
                        a_l_n   = addr;
                        d_l_n   = din;
                    end else begin
                        state_n = S_ERASE_WAIT;
                        cnt_n   = CNT_W'(ERASE_CYCLES - 1);
                        if (cmd == CMD_CHIP) begin
                            sw_addr_n = '0;
                            sw_end_n  = LAST_ADDR;
                        end else begin
                            sw_addr_n = {1'b0, addr} & ~SECT_MASK;
                            sw_end_n  = ({1'b0, addr} & ~SECT_MASK) | SECT_MASK;
                        end
                    end
                end
            end
            S_PROG: begin
                if (cnt == '0) begin
                    mem_we  = 1'b1;
                    mem_wa  = a_l;
                    mem_wd  = prog_old & d_l;
                    done_n  = 1'b1;
                    err_n   = |(d_l & ~prog_old);
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_ERASE_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_ERASE_SWEEP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_ERASE_SWEEP: begin
                mem_we = 1'b1;
                mem_wa = sw_addr[ADDR_W-1:0];
                mem_wd = '1;
                if (sw_addr == sw_end) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    sw_addr_n = sw_addr + (ADDR_W + 1)'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            a_l        <= '0;
            d_l        <= '0;
            sw_addr    <= '0;
            sw_end     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            a_l        <= a_l_n;
            d_l        <= d_l_n;
            sw_addr    <= sw_addr_n;
            sw_end     <= sw_end_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

    // Write enable is derived from state, which rst forces to IDLE, so an abort stops writes at once.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule
